// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// FSM state encoding, operation encoding and the saturation helper.
package serial_add_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the sequencer supports; the saturation helper works at this width
    localparam int MAX_WIDTH = 32;

    // Clamp value for an out-of-range result: all-ones for an add overflow,
    // all-zeros for a subtract borrow. Only the low 'width' bits are meaningful.
    function automatic logic [MAX_WIDTH-1:0] sat_value(input logic op, input int width);
        logic [MAX_WIDTH-1:0] ones;
        ones = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                ones[i] = 1'b1;
            end
        end
        return (op == OP_SUB) ? '0 : ones;
    endfunction

endpackage

// File: rtl/serial_add_sequencer_fulladder.sv
// Single 1-bit full-adder cell, time-shared by the sequencer across all bit positions.
module serial_add_sequencer_fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract engine: one full-adder cell processes the operands
// LSB first over WIDTH cycles, with a registered carry between bit steps.
// Operands arrive and results leave over valid/ready handshakes.
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             range_flag
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry_reg;
    logic             op_reg;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] final_sum;
    logic             final_flag;
    logic [WIDTH-1:0] clamp_val;

    serial_add_sequencer_fulladder u_fulladder (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // sh_a doubles as the result accumulator: the sum bit enters at the MSB as
    // the consumed operand bit leaves at the LSB, so after WIDTH steps it holds the sum.
    assign final_sum  = {fa_sum, sh_a[WIDTH-1:1]};
    assign final_flag = (op_reg == OP_SUB) ? ~fa_cout : fa_cout;
    assign clamp_val  = WIDTH'(sat_value(op_reg, WIDTH));

    // Sequencer FSM with operand shift registers, bit counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            result     <= '0;
            carry_out  <= 1'b0;
            range_flag <= 1'b0;
            sh_a       <= '0;
            sh_b       <= '0;
            carry_reg  <= 1'b0;
            op_reg     <= OP_ADD;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sh_a      <= a;
                        sh_b      <= op_sub ? ~b : b;
                        carry_reg <= op_sub;
                        op_reg    <= op_sub;
                        cnt       <= '0;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        sh_a      <= final_sum;
                        sh_b      <= {1'b0, sh_b[WIDTH-1:1]};
                        carry_reg <= fa_cout;
                        if (cnt == LAST_CNT) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            carry_out  <= fa_cout;
                            range_flag <= final_flag;
                            result     <= ((SATURATE != 0) && final_flag) ? clamp_val : final_sum;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: a wrapping and a saturating
// instance share the same stimulus and are compared against an arithmetic model.
module tb_serial_add_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             out_ready;

    logic             in_ready_w, busy_w, out_valid_w, carry_out_w, range_flag_w;
    logic [WIDTH-1:0] result_w;
    logic             in_ready_s, busy_s, out_valid_s, carry_out_s, range_flag_s;
    logic [WIDTH-1:0] result_s;

    int vectors     = 0;
    int miscompares = 0;

    logic [9:0] last_w;
    logic [9:0] last_s;

    serial_add_sequencer #(.WIDTH(WIDTH), .SATURATE(0)) dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready_w),
        .op_sub     (op_sub),
        .a          (a),
        .b          (b),
        .abort      (abort),
        .busy       (busy_w),
        .out_valid  (out_valid_w),
        .out_ready  (out_ready),
        .result     (result_w),
        .carry_out  (carry_out_w),
        .range_flag (range_flag_w)
    );

    serial_add_sequencer #(.WIDTH(WIDTH), .SATURATE(1)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready_s),
        .op_sub     (op_sub),
        .a          (a),
        .b          (b),
        .abort      (abort),
        .busy       (busy_s),
        .out_valid  (out_valid_s),
        .out_ready  (out_ready),
        .result     (result_s),
        .carry_out  (carry_out_s),
        .range_flag (range_flag_s)
    );

    always #5 clk = ~clk;

    // Unsigned arithmetic reference: returns {range_flag, carry_out, result}
    function automatic logic [9:0] model(input logic op, input logic [7:0] va,
                                         input logic [7:0] vb, input logic sat);
        logic [8:0] s;
        logic       co;
        logic       rf;
        logic [7:0] r;
        if (op) begin
            co = (va >= vb);
            rf = ~co;
            r  = va - vb;
            if (sat && rf) r = 8'h00;
        end else begin
            s  = {1'b0, va} + {1'b0, vb};
            co = s[8];
            rf = co;
            r  = s[7:0];
            if (sat && rf) r = 8'hFF;
        end
        return {rf, co, r};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkHandshake(input string tag, input logic exp_in_ready,
                                  input logic exp_busy, input logic exp_out_valid);
        checkOutput({tag, " in_ready_w"},  in_ready_w,  exp_in_ready);
        checkOutput({tag, " busy_w"},      busy_w,      exp_busy);
        checkOutput({tag, " out_valid_w"}, out_valid_w, exp_out_valid);
        checkOutput({tag, " in_ready_s"},  in_ready_s,  exp_in_ready);
        checkOutput({tag, " busy_s"},      busy_s,      exp_busy);
        checkOutput({tag, " out_valid_s"}, out_valid_s, exp_out_valid);
    endtask

    task automatic checkResults(input string tag, input logic [9:0] ew, input logic [9:0] es);
        checkOutput({tag, " result_w"},     result_w,     ew[7:0]);
        checkOutput({tag, " carry_out_w"},  carry_out_w,  ew[8]);
        checkOutput({tag, " range_flag_w"}, range_flag_w, ew[9]);
        checkOutput({tag, " result_s"},     result_s,     es[7:0]);
        checkOutput({tag, " carry_out_s"},  carry_out_s,  es[8]);
        checkOutput({tag, " range_flag_s"}, range_flag_s, es[9]);
    endtask

    // One complete transaction, entered and left on a falling edge
    task automatic applyStimulus(input logic op, input logic [7:0] va, input logic [7:0] vb,
                                 input int hold, input bit scramble);
        logic [9:0] ew;
        logic [9:0] es;
        int         lat;
        ew = model(op, va, vb, 1'b0);
        es = model(op, va, vb, 1'b1);
        checkOutput("idle in_ready", in_ready_w, 1);
        in_valid = 1'b1;
        op_sub   = op;
        a        = va;
        b        = vb;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        if (!scramble) in_valid = 1'b0;
        checkHandshake("run", 1'b0, 1'b1, 1'b0);
        while (!out_valid_w && lat < 40) begin
            if (scramble) begin
                a      = 8'($urandom);
                b      = 8'($urandom);
                op_sub = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        checkOutput("latency", lat, WIDTH + 1);
        checkHandshake("done", 1'b0, 1'b1, 1'b1);
        checkResults("done", ew, es);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkHandshake("backpressure", 1'b0, 1'b1, 1'b1);
            checkResults("backpressure", ew, es);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkHandshake("released", 1'b1, 1'b0, 1'b0);
        last_w = ew;
        last_s = es;
    endtask

    // Starts an operation and cancels it during the given RUN cycle
    task automatic applyAbort(input logic op, input logic [7:0] va, input logic [7:0] vb,
                              input int run_cycle);
        bit seen;
        in_valid = 1'b1;
        op_sub   = op;
        a        = va;
        b        = vb;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < run_cycle; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        checkHandshake("abort", 1'b1, 1'b0, 1'b0);
        checkResults("abort held", last_w, last_s);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid_w || out_valid_s) seen = 1'b1;
        end
        checkOutput("abort no out_valid", seen, 0);
    endtask

    initial begin
        logic [7:0] dir_a [0:7];
        logic [7:0] dir_b [0:7];
        logic       dir_op[0:7];
        dir_op = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        dir_a  = '{8'h3C, 8'hF0, 8'h10, 8'h20, 8'hFF, 8'h00, 8'h00, 8'h00};
        dir_b  = '{8'h0F, 8'h20, 8'h20, 8'h10, 8'h01, 8'h00, 8'h01, 8'h00};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        last_w    = '0;
        last_s    = '0;

        #12;
        $display("[TB] checking reset state");
        checkHandshake("reset", 1'b1, 1'b0, 1'b0);
        checkResults("reset", 10'h0, 10'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        foreach (dir_a[i]) applyStimulus(dir_op[i], dir_a[i], dir_b[i], 0, 1'b0);

        $display("[TB] backpressure and sampling at transfer");
        applyStimulus(1'b0, 8'h3C, 8'h0F, 5, 1'b0);
        applyStimulus(1'b1, 8'h10, 8'h20, 3, 1'b1);

        $display("[TB] abort handling");
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        checkHandshake("idle abort", 1'b1, 1'b0, 1'b0);
        applyAbort(1'b0, 8'hF0, 8'h20, 4);
        applyStimulus(1'b0, 8'h3C, 8'h0F, 1, 1'b0);

        $display("[TB] asynchronous reset mid-run");
        in_valid = 1'b1;
        op_sub   = 1'b0;
        a        = 8'hAA;
        b        = 8'h55;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkHandshake("async reset", 1'b1, 1'b0, 1'b0);
        checkResults("async reset", 10'h0, 10'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        last_w = '0;
        last_s = '0;
        @(negedge clk);

        $display("[TB] randomized vectors");
        for (int n = 0; n < 30; n++) begin
            applyStimulus(1'($urandom), 8'($urandom), 8'($urandom),
                          int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Bit-serial add/subtract engine that time-shares one 1-bit full-adder cell across WIDTH bits, LSB first, with a registered carry.
- Used by the RGB channel path for brightness and step updates (channel_level ± delta), where area matters more than latency.
- Uses a valid/ready handshake on both operand input and result output.
- Optional saturation clamps results to the 0..2^WIDTH-1 channel range.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- SATURATE, 0, 1 = clamp the result on unsigned overflow/borrow; 0 = wrap.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE; the transfer happens when in_valid && in_ready.
- op_sub  input  1  0 = A+B, 1 = A−B; sampled at transfer.
- a  input  WIDTH  operand A; sampled at transfer.
- b  input  WIDTH  operand B; sampled at transfer.
- abort  input  1  synchronous cancel of the operation in flight.
- busy  output  1  high in RUN or DONE.
- out_valid  output  1  result available; high in DONE only.
- out_ready  input  1  result consumer ready.
- result  output  WIDTH  sum/difference, after saturation if enabled.
- carry_out  output  1  raw carry from the MSB bit step.
- range_flag  output  1  add: carry_out; sub: ~carry_out (borrow). Reported regardless of SATURATE.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE.
  - in_ready = 1; busy = 0; out_valid = 0.
  - result = 0; carry_out = 0; range_flag = 0.
  - Shift registers, bit counter and carry register = 0.
- Reset asserted mid-operation discards everything. After deassertion the block behaves as if just reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On transfer (cycle T): latch sh_a = a and sh_b = op_sub ? ~b : b; carry_reg = op_sub; store op_sub; cnt = 0; enter RUN.
  - in_valid without a transfer has no effect.
- RUN (cycles T+1 .. T+WIDTH, exactly WIDTH cycles):
  - Full-adder inputs: sh_a[0], sh_b[0], carry_reg.
  - Each cycle: sum bit shifts into the result register from the MSB side; sh_a and sh_b shift right; carry_reg <= Cout; cnt increments.
  - When cnt == WIDTH−1: next state is DONE.
  - On entry to DONE: carry_out = final Cout and range_flag is computed. If SATURATE = 1 and range_flag = 1, result is forced to all-ones (add) or all-zeros (sub).
- DONE:
  - out_valid = 1 starting at cycle T+WIDTH+1.
  - result, carry_out and range_flag are held stable while out_valid is high and out_ready is low.
  - out_valid && out_ready → IDLE next cycle, so in_ready = 1 at the following cycle.
  - No same-cycle re-accept.
- Latency: accept to out_valid = WIDTH+1 cycles. Minimum issue interval = WIDTH+2 cycles.
- abort:
  - In RUN or DONE: go to IDLE next cycle. out_valid deasserts and no result is delivered.
  - result, carry_out and range_flag keep their last values.
  - abort in IDLE is ignored.
  - abort has priority over out_ready in the same cycle.
- in_valid asserted during RUN/DONE is ignored, because in_ready = 0.
- All arithmetic is unsigned modulo 2^WIDTH. Subtraction uses two's complement via ~B with carry-in 1.
- Counter width is $clog2(WIDTH). The counter never wraps, because the RUN exit happens at WIDTH−1.

Decomposition:
- Shared package holds:
  - state enum (IDLE/RUN/DONE);
  - op encoding constants (OP_ADD = 0, OP_SUB = 1);
  - a function computing the saturation value from op and WIDTH.
- One sub-module: the existing 1-bit fulladder cell, instantiated exactly once for the datapath.
- FSM, shift registers and counter stay in serial_add_sequencer.

Test Plan:
- WIDTH=8, add, a=0x3C, b=0x0F, accept at T → out_valid rises at T+9; result=0x4B, carry_out=0, range_flag=0.
- Add overflow, a=0xF0, b=0x20:
  - SATURATE=0 → result=0x10, carry_out=1, range_flag=1.
  - SATURATE=1 → result=0xFF, range_flag=1.
- Sub:
  - a=0x10, b=0x20 → SATURATE=0: result=0xF0, carry_out=0, range_flag=1; SATURATE=1: result=0x00.
  - a=0x20, b=0x10 → result=0x10, range_flag=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, result and flags stable; in_ready=0; then out_ready=1 → IDLE, in_ready=1 next cycle.
- Abort and reset:
  - abort at the 4th RUN cycle → no out_valid pulse; in_ready=1 the next cycle; a new request completes correctly.
  - rst_n low mid-RUN → all outputs at reset values immediately (asynchronous).
- in_valid held high with changing a/b during RUN → result reflects only the operands sampled at transfer. Back-to-back requests are spaced ≥10 cycles apart for WIDTH=8.
